// File: rtl/array_pkg.sv
// Shared types and constants for the systolic array feeder.
// Holds the feeder state encoding and the flush-length helper.
package array_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DONE
  } feeder_state_t;

  // Cycles needed for the last beat to cross the far corner of the array.
  function automatic int flush_cycles(input int size);
    return 2 * size - 1;
  endfunction

endpackage

// File: rtl/array_feeder_skew_line.sv
// Fixed-depth delay line for one feeder lane; shifts every cycle.
// Lane n of the feeder uses DEPTH = n+1 to build the diagonal wavefront.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DEPTH-1:0][DW-1:0] stages;

  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        stages[s] <= stages[s-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/array_feeder.sv
// Sequencer/transmitter for a SIZE x SIZE systolic MAC array: clear, skewed feed, flush, done.
// Optional FEEDER_STALL_CNT_EN adds a 16-bit count of FEED cycles without a valid beat.
module array_feeder
  import array_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DW   = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE-1:0][DW-1:0]  a_col_in,
  input  logic [SIZE-1:0][DW-1:0]  b_row_in,
  output logic [SIZE-1:0][DW-1:0]  a_out,
  output logic [SIZE-1:0][DW-1:0]  b_out,
  output logic                     load_en,
  output logic                     mult_en,
  output logic                     acc_en,
  output logic                     busy,
  output logic                     done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int CNT_W     = $clog2(2 * SIZE) + 1;
  localparam int FLUSH_CYC = flush_cycles(SIZE);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(FLUSH_CYC - 1);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in FEED and depends on state alone, never on in_valid.
  feeder_state_t state, state_next;

  logic [CNT_W-1:0]         beat_cnt;
  logic [CNT_W-1:0]         flush_cnt;
  logic                     accept;
  logic [SIZE-1:0][DW-1:0]  a_lane_in;
  logic [SIZE-1:0][DW-1:0]  b_lane_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load_en    = 1'b0;
    mult_en    = 1'b0;
    acc_en     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        load_en    = 1'b1;
        state_next = FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        mult_en  = 1'b1;
        acc_en   = 1'b1;
        if (in_valid && (beat_cnt == LAST_BEAT)) state_next = FLUSH;
      end
      FLUSH: begin
        mult_en = 1'b1;
        acc_en  = 1'b1;
        if (flush_cnt == LAST_FLUSH) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (state != FEED) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state != FLUSH)) begin
      flush_cnt <= '0;
    end else begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Bubbles and flush cycles push zeros so every accumulator sees +0 there.
  assign a_lane_in = accept ? a_col_in : '0;
  assign b_lane_in = accept ? b_row_in : '0;

  for (genvar n = 0; n < SIZE; n++) begin : g_lane
    skew_line #(.DEPTH(n + 1), .DW(DW)) u_a_skew (
      .clk   (clk),
      .reset (reset),
      .din   (a_lane_in[n]),
      .dout  (a_out[n])
    );
    skew_line #(.DEPTH(n + 1), .DW(DW)) u_b_skew (
      .clk   (clk),
      .reset (reset),
      .din   (b_lane_in[n]),
      .dout  (b_out[n])
    );
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if ((state == FEED) && !in_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_array_feeder.sv
// Bench for array_feeder: lane-timing scoreboard, behavioural array model, job table.
// Define FEEDER_STALL_CNT_EN to include the stall counter checks.
module tb_array_feeder;

  localparam int SIZE = 4;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready;
  logic load_en, mult_en, acc_en, busy, done;
  logic [SIZE-1:0][DW-1:0] a_col_in, b_row_in, a_out, b_out;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  array_feeder #(.SIZE(SIZE), .DW(DW)) dut (
`ifdef FEEDER_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col_in  (a_col_in),
    .b_row_in  (b_row_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .load_en   (load_en),
    .mult_en   (mult_en),
    .acc_en    (acc_en),
    .busy      (busy),
    .done      (done)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Job matrices: a_m[i][k] = A[i][k], b_m[k][j] = B[k][j]
  logic [DW-1:0] a_m[SIZE][SIZE];
  logic [DW-1:0] b_m[SIZE][SIZE];

  // Behavioural output-stationary array driven by the feeder outputs
  int            acc[SIZE][SIZE];
  logic [DW-1:0] ap[SIZE][SIZE];
  logic [DW-1:0] bp[SIZE][SIZE];
  logic [DW-1:0] a_at, b_at;

  always @(negedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        a_at = (j == 0) ? a_out[i] : ap[i][j-1];
        b_at = (i == 0) ? b_out[j] : bp[i-1][j];
        if (load_en) acc[i][j] = 0;
        else if (mult_en && acc_en) acc[i][j] = acc[i][j] + int'(a_at) * int'(b_at);
      end
    end
    for (int i = SIZE - 1; i >= 0; i--) begin
      for (int j = SIZE - 1; j >= 0; j--) begin
        ap[i][j] = (j == 0) ? a_out[i] : ap[i][j-1];
        bp[i][j] = (i == 0) ? b_out[j] : bp[i-1][j];
      end
    end
  end

  // Lane-timing scoreboard: beat accepted at edge c must show on lane n after edge c+n
  int cyc = 100;
  bit chk_en = 1'b0;
  logic hv[64];
  logic [SIZE-1:0][DW-1:0] ha[64], hb[64];
  logic [SIZE-1:0][DW-1:0] exp_a, exp_b;
  int done_total = 0;

  initial for (int i = 0; i < 64; i++) hv[i] = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 64; i++) hv[i] = 1'b0;
    end else begin
      hv[cyc % 64] = in_valid && in_ready;
      ha[cyc % 64] = a_col_in;
      hb[cyc % 64] = b_row_in;
    end
  end

  always @(negedge clk) begin
    if (done) done_total++;
    if (chk_en) begin
      for (int n = 0; n < SIZE; n++) begin
        exp_a[n] = hv[(cyc - n) % 64] ? ha[(cyc - n) % 64][n] : '0;
        exp_b[n] = hv[(cyc - n) % 64] ? hb[(cyc - n) % 64][n] : '0;
      end
      check("lane_a", a_out, exp_a);
      check("lane_b", b_out, exp_b);
    end
  end

  task automatic fill_mats(input int pattern);
    for (int i = 0; i < SIZE; i++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (pattern == 0) begin
          a_m[i][k] = (i == k) ? 8'd1 : 8'd0;
          b_m[i][k] = DW'(4 * i + k + 1);
        end else begin
          a_m[i][k] = DW'($urandom_range(0, 255));
          b_m[i][k] = DW'($urandom_range(0, 255));
        end
      end
    end
    if (pattern == 2) begin
      a_m[3][0] = 8'h55;
      a_m[0][0] = 8'hAA;
    end
  endtask

  task automatic push_golden();
    int sum;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        sum = 0;
        for (int k = 0; k < SIZE; k++) sum += int'(a_m[i][k]) * int'(b_m[k][j]);
        exp_q.push_back(32'(sum));
      end
    end
  endtask

  task automatic drive_beat(input int k);
    in_valid = 1'b1;
    for (int n = 0; n < SIZE; n++) begin
      a_col_in[n] = a_m[n][k];
      b_row_in[n] = b_m[k][n];
    end
  endtask

  // Called on a negedge in IDLE; returns on the negedge where done is high.
  task automatic run_job(input int stall_after, input int stall_len, input bit noise,
                         output int lat, output int feed_cnt, output int load_cnt);
    int k, stall_rem;
    bit got_done;
    logic [31:0] e;
    push_golden();
    k = 0; stall_rem = stall_len; lat = 0; feed_cnt = 0; load_cnt = 0; got_done = 0;
    start = 1'b1;
    while (!got_done && lat < 100) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      in_valid = 1'b0;
      a_col_in = '0;
      b_row_in = '0;
      if (load_en) load_cnt++;
      if (done) begin
        got_done = 1'b1;
      end else if (in_ready) begin
        feed_cnt++;
        if (noise && k == 1) start = 1'b1;
        if (k == stall_after && stall_rem > 0) stall_rem--;
        else if (k < SIZE) begin
          drive_beat(k);
          k++;
        end
      end else if (noise && busy) begin
        start = 1'b1;
        in_valid = 1'b1;
        a_col_in = {SIZE{8'($urandom_range(0, 255))}};
        b_row_in = {SIZE{8'($urandom_range(0, 255))}};
      end
    end
    if (!got_done) begin
      check("done_timeout", 1, 0);
      repeat (SIZE * SIZE) void'(exp_q.pop_back());
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          e = exp_q.pop_front();
          check($sformatf("product_%0d_%0d", i, j), 32'(acc[i][j]), e);
        end
      end
`ifdef FEEDER_STALL_CNT_EN
      check("stall_cnt", stall_cnt, 16'(stall_len));
`endif
    end
  endtask

  typedef struct {
    int pattern;
    int stall_after;
    int stall_len;
    bit noise;
    int exp_lat;
    int exp_feed;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, feed_cnt, load_cnt, d0, k;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    a_col_in = '0; b_row_in = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_load", load_en, 0);
    check("rst_mult", mult_en, 0);
    check("rst_acc", acc_en, 0);
    check("rst_a_out", a_out, 0);
    check("rst_b_out", b_out, 0);
`ifdef FEEDER_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // pattern, stall_after, stall_len, noise, latency start->done, FEED cycles
    vecs[0] = '{0, 0, 0, 1'b0, 13, 4};
    vecs[1] = '{2, 0, 0, 1'b0, 13, 4};
    vecs[2] = '{1, 2, 2, 1'b0, 15, 6};
    vecs[3] = '{1, 0, 0, 1'b1, 13, 4};
    vecs[4] = '{1, 0, 1, 1'b0, 14, 5};
    vecs[5] = '{1, 3, 3, 1'b0, 16, 7};

    foreach (vecs[v]) begin
      fill_mats(vecs[v].pattern);
      run_job(vecs[v].stall_after, vecs[v].stall_len, vecs[v].noise, lat, feed_cnt, load_cnt);
      check($sformatf("latency_%0d", v), lat, vecs[v].exp_lat);
      check($sformatf("feed_cycles_%0d", v), feed_cnt, vecs[v].exp_feed);
      check($sformatf("load_pulses_%0d", v), load_cnt, 1);
      @(negedge clk);
      check($sformatf("idle_busy_%0d", v), busy, 0);
      check($sformatf("single_done_%0d", v), done, 0);
    end

    // Back-to-back: second start lands in the IDLE cycle right after done
    fill_mats(1);
    run_job(0, 0, 1'b0, lat, feed_cnt, load_cnt);
    check("b2b_lat_1", lat, 13);
    check("b2b_load_1", load_cnt, 1);
    @(negedge clk);
    fill_mats(1);
    run_job(0, 0, 1'b0, lat, feed_cnt, load_cnt);
    check("b2b_lat_2", lat, 13);
    check("b2b_load_2", load_cnt, 1);
    @(negedge clk);

    // Reset after beat 1 has been accepted
    fill_mats(1);
    start = 1'b1;
    k = 0;
    for (int t = 0; t < 10 && k < 2; t++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      if (in_ready) begin
        drive_beat(k);
        k++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    d0 = done_total;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_a_out", a_out, 0);
    check("midrst_b_out", b_out, 0);
    check("midrst_done", done, 0);
    repeat (20) @(negedge clk);
    #1;
    check("midrst_no_done", done_total, d0);
    @(negedge clk);
    fill_mats(1);
    run_job(0, 0, 1'b0, lat, feed_cnt, load_cnt);
    check("post_rst_lat", lat, 13);
    @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/array_feeder.md
Name: array_feeder

Overview:
- Sequencer and transmitter that drives the a_in/b_in/mult_en/acc_en/load_en inputs of the SIZE x SIZE systolic MAC array.
- Accepts matrix A one column per beat and matrix B one row per beat over a valid/ready handshake.
- Applies the diagonal wavefront skew the array needs: lane i is delayed i cycles.
- Sequences clear, compute and flush phases, then pulses done when the array accumulators hold A x B.

Parameters:
SIZE, 4, array dimension; number of lanes and number of input beats per job.
DW, 8, element width in bits; must equal the array element width.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a job; sampled only in IDLE
in_valid  input  1  a_col_in/b_row_in hold a valid beat
in_ready  output  1  feeder accepts a beat this cycle
a_col_in  input  SIZE x DW  beat k: element i = A[i][k]
b_row_in  input  SIZE x DW  beat k: element j = B[k][j]
a_out  output  SIZE x DW  skewed row lanes to array a_in
b_out  output  SIZE x DW  skewed column lanes to array b_in
load_en  output  1  accumulator clear/load strobe to array
mult_en  output  1  multiply enable to array
acc_en  output  1  accumulate enable to array
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; results valid on array d_out

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: state IDLE; a_out, b_out, all skew registers, load_en, mult_en, acc_en, in_ready, busy and done all 0; beat and flush counters 0.
- FSM states: IDLE, CLEAR, FEED, FLUSH, DONE.
- IDLE: start=1 moves to CLEAR. All other inputs are ignored.
- CLEAR: lasts exactly 1 cycle. load_en=1, mult_en=0, acc_en=0. Next state is FEED.
- FEED:
  - in_ready=1, mult_en=1, acc_en=1.
  - A beat is accepted on a cycle where in_valid & in_ready.
  - Beat counter counts 0..SIZE-1. Acceptance of beat SIZE-1 moves to FLUSH.
  - If in_valid=0, a bubble of zeros enters every lane in the same cycle. This keeps skew alignment and contributes 0 to every accumulator.
- FLUSH:
  - in_ready=0, mult_en=1, acc_en=1; zeros enter all lanes.
  - Lasts FLUSH_CYC = 2*SIZE-1 cycles, counted by the flush counter, then moves to DONE.
- DONE: done=1 for 1 cycle; mult_en=0, acc_en=0. Next state is IDLE.
- Skew timing: a beat accepted at clock edge t appears as a_out[i] = A[i][k] and b_out[j] = B[k][j] during cycle t+1+i (respectively t+1+j). Lane 0 has 1 register stage; lane n has n+1 stages.
- Lane outputs are 0 in every cycle that carries no beat.
- start while busy=1 is ignored. No queueing.
- Back-to-back jobs: start may be asserted in the IDLE cycle immediately after done. Minimum job length is 1+SIZE+(2*SIZE-1)+1 cycles.
- Reset mid-operation: next cycle returns to IDLE with all lanes zeroed and no done pulse. Array contents are then undefined until the next CLEAR.
- in_valid outside FEED: no effect. in_ready is 0 there, so the upstream source holds its data.
- Width rule: data passes through unmodified. There is no arithmetic on data, only counters of width $clog2(2*SIZE)+1.

Optional Feature:
- Macro: FEEDER_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits.
  - Counts FEED cycles with in_valid=0, saturating at 16'hFFFF.
  - Cleared to 0 on the cycle start is accepted and on reset.
  - Holds its value after done.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package array_pkg holds:
  - DATA_W = 8
  - the feeder_state_t enum (IDLE, CLEAR, FEED, FLUSH, DONE)
  - function flush_cycles(size), returning 2*size-1
- One sub-module, skew_line:
  - parameterised DEPTH x DW shift register with synchronous reset, shifting every cycle.
  - Instantiated 2*SIZE times, with lane n using DEPTH = n+1.

Test Plan:
- Identity job, SIZE=4: A=I, B[k][j]=4k+j+1, in_valid held high. Expect:
  - load_en high for 1 cycle, 4 beats in 4 cycles, done 13 cycles after start.
  - Array d_out[select=i*4+j] equals B[i][j].
- Skew check: single job, probe a_out[3]. Beat 0 (A[3][0]=8'h55) appears exactly 4 cycles after its accepting edge; a_out[0] shows A[0][0] after 1 cycle.
- Stalls: drop in_valid for 2 cycles between beats 1 and 2, using random A and B. Expect:
  - done delayed by exactly 2 cycles.
  - Array result equals the golden A x B.
  - With FEEDER_STALL_CNT_EN defined, stall_cnt=2.
- start asserted during FEED and FLUSH: no state change, a single done pulse, result unaffected.
- Reset asserted in FEED after beat 1: next cycle busy=0, a_out=b_out=0, no done pulse. A following full job produces the correct product.
- Back-to-back: two jobs with start asserted in the IDLE cycle right after done. Both results are correct and there is exactly one load_en pulse per job.
